// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU, and the result is returned on a valid/ready channel.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,

    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [2:0]         alu_ctrl_q, alu_ctrl_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant0, grant1;
    logic               accept;
    logic               op_legal;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        grant0       = req0_valid_i & (~req1_valid_i | ~ptr_q);
        grant1       = req1_valid_i & (~req0_valid_i | ptr_q);
        req0_ready_o = (state_q == IDLE) & grant0 & ~rst_i;
        req1_ready_o = (state_q == IDLE) & grant1 & ~rst_i;
        accept       = req0_ready_o | req1_ready_o;
        sel_op       = grant1 ? req1_op_i : req0_op_i;
        sel_a        = grant1 ? req1_a_i  : req0_a_i;
        sel_b        = grant1 ? req1_b_i  : req0_b_i;
        op_legal     = (sel_op <= OP_OR);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_id_d = grant1;
                    if (op_legal) begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_ctrl_d = sel_op;
                        cnt_d      = (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
                        rsp_err_d  = 1'b0;
                        state_d    = EXEC;
                    end else begin
                        // Illegal codes never reach the ALU; its inputs keep the last op.
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d = alu_data_i;
                    rsp_zero_d = alu_zero_i;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    ptr_d   = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_data0_o = alu_a_q;
    assign alu_data1_o = alu_b_q;
    assign alu_ctrl_o  = alu_ctrl_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU answers the DUT, and expected
// responses are queued at grant time and checked by a separate response monitor.
module tb_alu_arbiter;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_data0, alu_data1, alu_res;
    logic [2:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];

    alu_arbiter #(.WIDTH(32), .MUL_LAT(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_a_i(req1_a), .req1_b_i(req1_b),
        .alu_data0_o(alu_data0), .alu_data1_o(alu_data1), .alu_ctrl_o(alu_ctrl),
        .alu_data_i(alu_res), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU
    always_comb begin
        alu_res = 32'h0;
        case (alu_ctrl)
            3'b000:  alu_res = alu_data0 + alu_data1;
            3'b001:  alu_res = alu_data0 - alu_data1;
            3'b010:  alu_res = alu_data0 * alu_data1;
            3'b011:  alu_res = alu_data0 & alu_data1;
            3'b100:  alu_res = alu_data0 | alu_data1;
            default: alu_res = 32'h0;
        endcase
        alu_zero = (alu_res == 32'h0);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit id, input bit v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err,
                 alu_ctrl, alu_data0, alu_data1, rsp_data}, 128'h0);
    endtask

    // Response monitor: samples 2 time units after the falling edge.
    always @(negedge clk) begin
        rsp_t e;
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected response", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("response", {rsp_id, rsp_data, rsp_zero, rsp_err}, e);
            end
        end
    end

    // Issue one op, check grant, ALU port stability and response latency.
    task automatic issue(input bit id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input bit ez,
                         input bit ee, input int lat, input string nm);
        int k;
        bit got;
        logic [31:0] s0, s1;
        logic [2:0] sc;
        @(negedge clk);
        s0 = alu_data0; s1 = alu_data1; sc = alu_ctrl;
        drive(id, 1'b1, op, a, b);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (id ? req1_ready : req0_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk({nm, " grant"}, got, 1'b1);
        if (!got) begin
            drive(id, 1'b0, op, a, b);
            return;
        end
        sb_q.push_back({id, ed, ez, ee});
        @(posedge clk);
        @(negedge clk);
        drive(id, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        k = 1;
        while (!rsp_valid && k < 40) begin
            if (!ee) chk({nm, " alu stable"}, {alu_ctrl, alu_data0, alu_data1}, {op, a, b});
            @(negedge clk);
            #1;
            k++;
        end
        chk({nm, " latency"}, k, lat + 1);
        if (ee) chk({nm, " alu untouched"}, {alu_ctrl, alu_data0, alu_data1}, {sc, s0, s1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        bit g;
        logic [35:0] held;

        rst = 1'b1; rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        #3;
        chk_all_zero("reset outputs");
        @(negedge clk);
        rst = 1'b0;

        // 1: ADD from req0
        issue(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1, "add");
        // 2: MUL from req1, low bits wrap to zero
        issue(1'b1, 3'b010, 32'h10000, 32'h10000, 32'h0, 1'b1, 1'b0, 3, "mul");

        // 3: both requesters hold valid; grants must alternate starting at 0
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b001, 32'd9, 32'd9);
        drive(1'b1, 1'b1, 3'b100, 32'd1, 32'd2);
        grants = 0;
        for (int c = 0; c < 100 && grants < 4; c++) begin
            #1;
            chk("single ready", req0_ready & req1_ready, 1'b0);
            if (req0_ready | req1_ready) begin
                g = req1_ready;
                chk("rr order", g, grants[0]);
                if (g) sb_q.push_back({1'b1, 32'd3, 1'b0, 1'b0});
                else   sb_q.push_back({1'b0, 32'd0, 1'b1, 1'b0});
                grants++;
            end
            @(negedge clk);
        end
        chk("rr grant count", grants, 4);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (6) @(negedge clk);

        // 4: consumer stalls for 5 cycles
        rsp_ready = 1'b0;
        issue(1'b0, 3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, "stall add");
        held = {rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err};
        drive(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
        drive(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stall rsp held", {rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err}, held);
            chk("stall readys low", {req0_ready, req1_ready}, 2'b00);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall release", rsp_valid, 1'b0);

        // 5: illegal op code
        issue(1'b0, 3'b110, 32'hdead, 32'hbeef, 32'h0, 1'b0, 1'b1, 0, "illegal");

        // 6: reset during MUL exec abandons the op and returns the pointer to 0
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'd7, 32'd6);
        #1;
        chk("abort grant", req0_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset outputs");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 3'b011, 32'hf, 32'h3);
        #1;
        chk("post reset grant", {req0_ready, req1_ready}, 2'b10);
        if (req0_ready) sb_q.push_back({1'b0, 32'd2, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (8) @(negedge clk);
        #3;
        chk("scoreboard drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
